// File: rtl/fir_pkg.sv
// Shared FIR definitions: FSM state encoding and the index-width helper
// used to size tap/pointer fields across the FIR blocks.
package fir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Bits needed to index n entries, never less than one.
    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// TAPS x WIDTH sample register file: one write port, one asynchronous read
// port, synchronously cleared so an unfilled history reads as zeros.
module fir_sample_ram #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [TAPS-1:0][WIDTH-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fir_tap_reader.sv
// Circular sample history: each accepted sample overwrites the oldest entry,
// then the whole history is streamed newest-first to the serial MAC stage.
module fir_tap_reader
    import fir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAPS  = 8,
    localparam int AW   = fir_clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_tap,
    output logic             out_last,
    input  logic             out_ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [AW-1:0]   r_k, w_k_nxt;
    logic            w_we;
    logic [WIDTH-1:0] w_rdata;

    fir_sample_ram #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (in_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_k      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_k      <= w_k_nxt;
        end
    end

    // Pointer wraps are explicit so non-power-of-two depths stay exact.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_k_nxt      = r_k;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_we         = 1'b1;
                    w_rd_ptr_nxt = r_wr_ptr;
                    w_wr_ptr_nxt = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + ONE;
                    w_k_nxt      = '0;
                    w_state_nxt  = ST_READ;
                end
            end
            ST_READ: begin
                if (out_ready) begin
                    if (r_k == LAST_IDX) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_k_nxt      = r_k + ONE;
                        w_rd_ptr_nxt = (r_rd_ptr == '0) ? LAST_IDX : r_rd_ptr - ONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output fields are zeroed outside READ so idle reads back as reset values.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_READ);
    assign out_data  = out_valid ? w_rdata : '0;
    assign out_tap   = out_valid ? r_k : '0;
    assign out_last  = out_valid && (r_k == LAST_IDX);

endmodule

// File: tb/tb_fir_tap_reader.sv
// Directed bench: per-cycle vector table on a TAPS=4 instance, plus a
// handshake-driven sequence on a TAPS=5 instance for non-power-of-two wrap.
module tb_fir_tap_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // TAPS=4 instance
    logic       rst4, iv4, ordy4;
    logic [7:0] id4;
    logic       ir4, ov4, last4;
    logic [7:0] od4;
    logic [1:0] tap4;

    // TAPS=5 instance
    logic       rst5, iv5, ordy5;
    logic [7:0] id5;
    logic       ir5, ov5, last5;
    logic [7:0] od5;
    logic [2:0] tap5;

    fir_tap_reader #(.WIDTH(8), .TAPS(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_tap(tap4), .out_last(last4),
        .out_ready(ordy4)
    );

    fir_tap_reader #(.WIDTH(8), .TAPS(5)) dut5 (
        .clk(clk), .rst(rst5), .in_valid(iv5), .in_data(id5), .in_ready(ir5),
        .out_valid(ov5), .out_data(od5), .out_tap(tap5), .out_last(last5),
        .out_ready(ordy5)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        int         tap;
        logic [7:0] data;
        logic       last;
        logic       ir;
    } vec_t;

    vec_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int row, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [7:0] id, input logic ordy,
                       input logic ov, input int tap, input logic [7:0] d,
                       input logic last, input logic ir);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.tap = tap; v.data = d; v.last = last; v.ir = ir;
        q.push_back(v);
    endtask

    // Accept one sample in IDLE, then four unstalled beats with the given data.
    task automatic seq4(input logic [7:0] s, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        add(0, 1, s, 1, 0, 0, 8'h00, 0, 1);
        add(0, 0, 0, 1, 1, 0, d0, 0, 0);
        add(0, 0, 0, 1, 1, 1, d1, 0, 0);
        add(0, 0, 0, 1, 1, 2, d2, 0, 0);
        add(0, 0, 0, 1, 1, 3, d3, 1, 0);
    endtask

    logic [7:0] exp5 [5];

    initial begin
        rst4 = 1; iv4 = 0; id4 = 0; ordy4 = 1;
        rst5 = 1; iv5 = 0; id5 = 0; ordy5 = 1;

        // single sample into an empty history
        seq4(8'h11, 8'h11, 8'h00, 8'h00, 8'h00);
        // reset with in_valid high must not write; then 0x01..0x05 with wrap
        add(1, 1, 8'hEE, 1, 0, 0, 8'h00, 0, 1);
        seq4(8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        seq4(8'h02, 8'h02, 8'h01, 8'h00, 8'h00);
        seq4(8'h03, 8'h03, 8'h02, 8'h01, 8'h00);
        seq4(8'h04, 8'h04, 8'h03, 8'h02, 8'h01);
        seq4(8'h05, 8'h05, 8'h04, 8'h03, 8'h02);
        // backpressure on tap 1 for three cycles
        add(0, 1, 8'h06, 1, 0, 0, 8'h00, 0, 1);
        add(0, 0, 0, 1, 1, 0, 8'h06, 0, 0);
        add(0, 0, 0, 0, 1, 1, 8'h05, 0, 0);
        add(0, 0, 0, 0, 1, 1, 8'h05, 0, 0);
        add(0, 0, 0, 0, 1, 1, 8'h05, 0, 0);
        add(0, 0, 0, 1, 1, 1, 8'h05, 0, 0);
        add(0, 0, 0, 1, 1, 2, 8'h04, 0, 0);
        add(0, 0, 0, 1, 1, 3, 8'h03, 1, 0);
        // in_valid held with 0xAA across READ: ignored until IDLE
        add(0, 1, 8'h07, 1, 0, 0, 8'h00, 0, 1);
        add(0, 1, 8'hAA, 1, 1, 0, 8'h07, 0, 0);
        add(0, 1, 8'hAA, 1, 1, 1, 8'h06, 0, 0);
        add(0, 1, 8'hAA, 1, 1, 2, 8'h05, 0, 0);
        add(0, 1, 8'hAA, 1, 1, 3, 8'h04, 1, 0);
        seq4(8'hAA, 8'hAA, 8'h07, 8'h06, 8'h05);
        // reset mid-sequence at tap 2, then a fresh sample
        add(0, 1, 8'h55, 1, 0, 0, 8'h00, 0, 1);
        add(0, 0, 0, 1, 1, 0, 8'h55, 0, 0);
        add(0, 0, 0, 1, 1, 1, 8'hAA, 0, 0);
        add(1, 0, 0, 1, 1, 2, 8'h07, 0, 0);
        seq4(8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 1, 0, 0, 8'h00, 0, 1);

        repeat (2) @(negedge clk);
        rst5 = 0;
        foreach (q[i]) begin
            @(negedge clk);
            chk("out_valid", i, int'(ov4),   int'(q[i].ov));
            chk("out_tap",   i, int'(tap4),  q[i].tap);
            chk("out_data",  i, int'(od4),   int'(q[i].data));
            chk("out_last",  i, int'(last4), int'(q[i].last));
            chk("in_ready",  i, int'(ir4),   int'(q[i].ir));
            rst4 = q[i].rst; iv4 = q[i].iv; id4 = q[i].id; ordy4 = q[i].ordy;
        end

        // TAPS=5: samples 0x01..0x07, final history read must be 07..03
        exp5[0] = 8'h07; exp5[1] = 8'h06; exp5[2] = 8'h05; exp5[3] = 8'h04; exp5[4] = 8'h03;
        for (int s = 1; s <= 7; s++) begin
            int cyc;
            int beats;
            cyc = 0;
            @(negedge clk);
            while (!ir5 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("t5 in_ready wait", s, int'(ir5), 1);
            iv5 = 1; id5 = 8'(s);
            beats = 0;
            cyc = 0;
            while (beats < 5 && cyc < 20) begin
                @(negedge clk);
                iv5 = 0;
                cyc++;
                if (ov5) begin
                    chk("t5 out_tap",  s * 10 + beats, int'(tap5),  beats);
                    chk("t5 out_last", s * 10 + beats, int'(last5), (beats == 4) ? 1 : 0);
                    if (s == 7) chk("t5 out_data", beats, int'(od5), int'(exp5[beats]));
                    beats++;
                end
            end
            chk("t5 beat count", s, beats, 5);
        end
        @(negedge clk);
        chk("t5 idle after seq", 0, int'(ir5), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tap_reader.md
# fir_tap_reader

Circular sample history with a sequenced tap read port for the time-multiplexed FIR datapath.
- Each accepted input sample is written over the oldest entry.
- The block then streams the full tap history, newest first (x[n], x[n-1], …, x[n-TAPS+1]), to the serial MAC stage over a valid/ready handshake.
- It is the reader-side counterpart of the sample delay chain.
- It sits between the sample source and the coefficient-multiply/accumulate stage.

## Interface
- `WIDTH`, default 8: sample width in bits.
- `TAPS`, default 8: history depth / filter length, ≥2, need not be a power of two.
- `AW` (localparam) = clog2(TAPS), minimum 1: tap-index width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input sample valid.
- `in_data` in WIDTH: input sample.
- `in_ready` out 1: block can accept a sample; high only in IDLE.
- `out_valid` out 1: tap beat valid.
- `out_data` out WIDTH: sample x[n-k] for the current tap k.
- `out_tap` out AW: tap index k, 0..TAPS-1.
- `out_last` out 1: high on the k = TAPS-1 beat only.
- `out_ready` in 1: MAC stage accepts the beat.

## Operation
- Storage is TAPS × WIDTH registers plus a write pointer `wr_ptr` (0..TAPS-1).
- All storage and pointers clear to 0 on rst, so the history reads as zeros until filled.
- FSM states:
  - IDLE:
    - `in_ready`=1, `out_valid`=0.
    - On `in_valid`&`in_ready`: write `in_data` at `wr_ptr`; set `rd_ptr`=`wr_ptr`; `wr_ptr`←`wr_ptr`+1 mod TAPS; `k`←0; go to READ.
  - READ:
    - `out_valid`=1, `in_ready`=0.
    - `out_data`=buf[`rd_ptr`], `out_tap`=`k`, `out_last`=(`k`==TAPS-1).
    - On `out_valid`&`out_ready`:
      - If `out_last`: go to IDLE.
      - Else: `k`←`k`+1; `rd_ptr`←`rd_ptr`-1 mod TAPS, wrapping 0→TAPS-1 explicitly, with no reliance on power-of-two overflow.
- Storage is never written in READ, so `out_data` is stable while stalled.
- `in_valid` in READ is ignored. Nothing is written, and the source must hold the sample until `in_ready`.
- Pointer wrap:
  - `wr_ptr` TAPS-1→0.
  - `rd_ptr` 0→TAPS-1.
  - Both are exact modulo TAPS.
- No arithmetic on sample data; samples pass bit-exact. Signedness is irrelevant.
- `rst` has priority over every event, including a handshake in the same cycle:
  - Next cycle: IDLE, `out_valid`=0, storage zeroed.
  - Any in-progress tap sequence is abandoned with no `out_last`.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `out_tap`=0, `out_data`=0.
  - `in_ready`=1 in the first cycle after rst deasserts.
  - `in_valid` is ignored while rst is high.
- Cycle 0: input handshake. Cycle 1: `out_valid`=1, `out_tap`=0, `out_data`=that sample.
- With `out_ready` held high, beats occupy cycles 1..TAPS, `out_last` is in cycle TAPS, and `in_ready`=1 in cycle TAPS+1.
- Throughput is one sample per TAPS+1 cycles.
- Backpressure: while `out_valid`&!`out_ready`, `out_data`/`out_tap`/`out_last` are held unchanged.
- Output fields are a function of registered state only, with no combinational path from `out_ready` or `in_valid`. `in_ready` is a function of state only.

## Structure
- Shared package `fir_pkg` holds:
  - FSM state encoding constants (`ST_IDLE`, `ST_READ`).
  - The clog2 function used for `AW`, shared with the other FIR blocks.
- Sub-module `fir_sample_ram` is the natural split:
  - TAPS×WIDTH register file.
  - One write port (`we`, `waddr`, `wdata`), one asynchronous read port (`raddr`→`rdata`), synchronous clear on `rst`.
- The top level holds the FSM, `wr_ptr`, `rd_ptr` and `k`.

## Test plan
All scenarios use WIDTH=8, TAPS=4 unless stated; `out_ready`=1 unless stated.
1. rst, then one sample 0x11 → beats (tap,data) = (0,0x11),(1,0x00),(2,0x00),(3,0x00), with `out_last` only on tap 3; `in_ready`=1 one cycle after the last beat.
2. Samples 0x01..0x05 each sent when `in_ready` → the 5th sequence reads 0x05,0x04,0x03,0x02 (`wr_ptr` wrapped, 0x01 overwritten).
3. `out_ready` low for 3 cycles while tap 1 is presented → `out_data`/`out_tap` held for all 3 cycles; no beat skipped or duplicated; `in_ready` stays 0.
4. `in_valid` held high with 0xAA throughout READ of the previous sample → not written during READ; accepted in the first IDLE cycle; the next sequence starts with 0xAA.
5. rst asserted at tap 2 → next cycle `out_valid`=0, `out_last` never seen; new sample 0x7F → 0x7F,0x00,0x00,0x00.
6. TAPS=5 build, samples 0x01..0x07 → the last sequence reads 0x07,0x06,0x05,0x04,0x03, checking non-power-of-two wrap of both pointers.
